msrr_shift_engine: RTL and testbench

MSRR_SHIFT_ENGINE -- requirements
Module: msrr_shift_engine

---
 rtl/msrr_shift_engine.sv | 117 +++++++++++
 tb/tb_msrr_shift_engine.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/msrr_shift_engine.sv
// Multi-mode shift register with a counted burst engine (IDLE/RUN).
// Define MSRR_PARITY_EN to add a registered even-parity output of Q.
//
// state | meaning
// IDLE  | selected mode applied every edge; start with a shift mode launches a burst
// RUN   | latched shift mode applied every edge until the remaining count expires
module msrr_shift_engine #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             Re,
   input  logic [2:0]       mode,
   input  logic             sIn,
   input  logic [WIDTH-1:0] pIn,
   input  logic             start,
   input  logic [CNT_W-1:0] count,
   output logic [WIDTH-1:0] Q,
   output logic             sOut,
`ifdef MSRR_PARITY_EN
   output logic             parity,
`endif
   output logic             busy,
   output logic             done
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] q_nxt;
   logic [CNT_W-1:0] cnt_rem, cnt_nxt;
   logic [2:0]       mode_lat, mode_nxt;
   logic             done_nxt;

   function automatic logic is_shift(input logic [2:0] m);
      return (m == 3'b001) || (m == 3'b010) || (m == 3'b011) ||
             (m == 3'b100) || (m == 3'b110);
   endfunction

   function automatic logic [WIDTH-1:0] step(input logic [2:0]       m,
                                             input logic [WIDTH-1:0] q,
                                             input logic             s,
                                             input logic [WIDTH-1:0] p);
      logic [WIDTH-1:0] r;
      case (m)
         3'b001:  r = {s, q[WIDTH-1:1]};
         3'b010:  r = {q[WIDTH-2:0], s};
         3'b011:  r = {q[0], q[WIDTH-1:1]};
         3'b100:  r = {q[WIDTH-2:0], q[WIDTH-1]};
         3'b101:  r = p;
         3'b110:  r = {q[WIDTH-1], q[WIDTH-1:1]};
         3'b111:  r = '0;
         default: r = q;
      endcase
      return r;
   endfunction

   always_comb begin
      state_nxt = state;
      q_nxt     = Q;
      cnt_nxt   = cnt_rem;
      mode_nxt  = mode_lat;
      done_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (start && is_shift(mode)) begin
               // Q is left untouched on the launch edge; a zero count completes at once
               if (count == '0) begin
                  done_nxt = 1'b1;
               end else begin
                  state_nxt = RUN;
                  cnt_nxt   = count;
                  mode_nxt  = mode;
               end
            end else begin
               q_nxt = step(mode, Q, sIn, pIn);
            end
         end
         RUN: begin
            q_nxt   = step(mode_lat, Q, sIn, pIn);
            cnt_nxt = cnt_rem - CNT_W'(1);
            if (cnt_rem == CNT_W'(1)) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!Re) begin
         state    <= IDLE;
         Q        <= '0;
         cnt_rem  <= '0;
         mode_lat <= 3'b000;
         done     <= 1'b0;
      end else begin
         state    <= state_nxt;
         Q        <= q_nxt;
         cnt_rem  <= cnt_nxt;
         mode_lat <= mode_nxt;
         done     <= done_nxt;
      end
   end

`ifdef MSRR_PARITY_EN
   always_ff @(posedge clk) begin
      if (!Re) parity <= 1'b0;
      else     parity <= ^q_nxt;
   end
`endif

   assign busy = (state == RUN);
   assign sOut = Q[0];

endmodule

// File: tb/tb_msrr_shift_engine.sv
// Directed self-checking bench for msrr_shift_engine (WIDTH=8, CNT_W=4).
module tb_msrr_shift_engine;

   logic       clk = 1'b0;
   logic       Re = 1'b0;
   logic [2:0] mode = 3'b000;
   logic       sIn = 1'b0;
   logic [7:0] pIn = 8'h00;
   logic       start = 1'b0;
   logic [3:0] count = 4'd0;
   logic [7:0] Q;
   logic       sOut, busy, done;
`ifdef MSRR_PARITY_EN
   logic       parity;
`endif

   int checks = 0;
   int errors = 0;

   msrr_shift_engine #(.WIDTH(8), .CNT_W(4)) dut (
      .clk(clk), .Re(Re), .mode(mode), .sIn(sIn), .pIn(pIn),
      .start(start), .count(count), .Q(Q), .sOut(sOut),
`ifdef MSRR_PARITY_EN
      .parity(parity),
`endif
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk3(input string tag, input logic [7:0] eq, input logic eb, input logic ed);
      check({tag, " Q"}, 64'(Q), 64'(eq));
      check({tag, " busy"}, 64'(busy), 64'(eb));
      check({tag, " done"}, 64'(done), 64'(ed));
   endtask

   initial begin
      // reset
      Re = 1'b0; start = 1'b1; mode = 3'b011; count = 4'd3;
      tick();
      chk3("reset", 8'h00, 1'b0, 1'b0);
      check("reset sOut", 64'(sOut), 64'd0);

      // parallel load
      Re = 1'b1; start = 1'b0; mode = 3'b101; pIn = 8'hA5;
      tick();
      chk3("load A5", 8'hA5, 1'b0, 1'b0);
      check("load sOut", 64'(sOut), 64'd1);

      mode = 3'b111;
      tick();
      check("clear", 64'(Q), 64'h00);

      // free-running shift right with sIn=1
      mode = 3'b001; sIn = 1'b1;
      tick();
      check("shr 1st", 64'(Q), 64'h80);
      for (int i = 0; i < 7; i++) tick();
      check("shr 8th", 64'(Q), 64'hFF);

      mode = 3'b010; sIn = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      check("shl x3", 64'(Q), 64'hF8);

      mode = 3'b000;
      tick();
      check("hold", 64'(Q), 64'hF8);

      // rotate-right burst, count 3, inputs changed during RUN
      mode = 3'b101; pIn = 8'h81;
      tick();
      start = 1'b1; mode = 3'b011; count = 4'd3;
      tick();
      chk3("ror k", 8'h81, 1'b1, 1'b0);
      start = 1'b1; mode = 3'b101; pIn = 8'h00; count = 4'd0;
      tick();
      chk3("ror k+1", 8'hC0, 1'b1, 1'b0);
      tick();
      chk3("ror k+2", 8'h60, 1'b1, 1'b0);
      start = 1'b0;
      tick();
      chk3("ror k+3", 8'h30, 1'b0, 1'b1);

      // zero-count burst launched on the done edge
      start = 1'b1; mode = 3'b100; count = 4'd0;
      tick();
      chk3("cnt0 edge", 8'h30, 1'b0, 1'b1);
      start = 1'b0; mode = 3'b000;
      tick();
      chk3("cnt0 after", 8'h30, 1'b0, 1'b0);

      // asr burst aborted by reset
      mode = 3'b101; pIn = 8'h80;
      tick();
      start = 1'b1; mode = 3'b110; count = 4'd2;
      tick();
      chk3("asr k", 8'h80, 1'b1, 1'b0);
      start = 1'b0; Re = 1'b0;
      tick();
      chk3("abort", 8'h00, 1'b0, 1'b0);
      Re = 1'b1; mode = 3'b000;
      tick();
      chk3("post abort", 8'h00, 1'b0, 1'b0);

      // asr burst to completion
      mode = 3'b101; pIn = 8'h80;
      tick();
      start = 1'b1; mode = 3'b110; count = 4'd2;
      tick();
      start = 1'b0;
      tick();
      chk3("asr k+1", 8'hC0, 1'b1, 1'b0);
      tick();
      chk3("asr k+2", 8'hE0, 1'b0, 1'b1);

      // start with a non-shift mode is a plain load
      start = 1'b1; mode = 3'b101; pIn = 8'h3C; count = 4'd2;
      tick();
      chk3("start load", 8'h3C, 1'b0, 1'b0);

      // shift-left burst consumes live sIn
      mode = 3'b010; sIn = 1'b1;
      tick();
      chk3("shl k", 8'h3C, 1'b1, 1'b0);
      start = 1'b0;
      tick();
      chk3("shl k+1", 8'h79, 1'b1, 1'b0);
      sIn = 1'b0;
      tick();
      chk3("shl k+2", 8'hF2, 1'b0, 1'b1);
      mode = 3'b000;
      tick();
      check("shl done fall", 64'(done), 64'd0);

`ifdef MSRR_PARITY_EN
      mode = 3'b101; pIn = 8'h07;
      tick();
      check("parity 07", 64'(parity), 64'd1);
      pIn = 8'h03;
      tick();
      check("parity 03", 64'(parity), 64'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
